friet_stream_buffer_out_fifo: RTL and testbench
===============================================

// Module: friet_stream_buffer_out_fifo
// PURPOSE
//  Parametrised successor of the single-word output buffer: a DEPTH-entry queue of wide words with per-word
//  byte size and last flag, drained as DOUT_WIDTH chunks through a width down-converter.
//  Sits between the FRIET core output and the narrow external bus; absorbs core bursts while the bus stalls.
//  New vs single-word buffer: multi-entry storage, zero-size last words emitted, tail byte zeroing, byte count.
// PARAMETERS
//  DIN_WIDTH        128  input word width, bits; multiple of DOUT_WIDTH, ratio R=DIN_WIDTH/DOUT_WIDTH a power of 2
//  DIN_SIZE_WIDTH   4    log2(DIN_WIDTH/8); din_size is DIN_SIZE_WIDTH+1 bits, bytes
//  DOUT_WIDTH       32   output chunk width, bits
//  DOUT_SIZE_WIDTH  2    log2(DOUT_WIDTH/8); dout_size is DOUT_SIZE_WIDTH+1 bits, bytes
//  DEPTH            4    queue entries, power of 2, >=2
//  DEPTH_WIDTH      2    log2(DEPTH)
//  ZERO_TAIL        1    1: dout bytes at index >= dout_size forced to 0; 0: raw buffer bytes
// PORTS
//  clk        in   1                              clock, all state on rising edge
//  rst_n      in   1                              asynchronous active-low reset
//  din        in   DIN_WIDTH                      input word, byte 0 = din[7:0]
//  din_size   in   DIN_SIZE_WIDTH+1               valid bytes in din, 0..DIN_WIDTH/8
//  din_last   in   1                              din is final word of message
//  din_valid  in   1                              input handshake
//  din_ready  out  1                              input handshake
//  dout       out  DOUT_WIDTH                     output chunk, byte 0 = dout[7:0]
//  dout_size  out  DOUT_SIZE_WIDTH+1              valid bytes in dout, 0..DOUT_WIDTH/8
//  dout_valid out  1                              output handshake
//  dout_ready in   1                              output handshake
//  dout_last  out  1                              final chunk of message
//  count      out  DEPTH_WIDTH+1                  words held in queue (excl. output stage)
//  size       out  DIN_SIZE_WIDTH+DEPTH_WIDTH+1   total bytes held (queue + remaining in output stage)
// BEHAVIOUR
//  - Reset (rst_n=0, async): queue empty, stage empty; din_ready=0 while in reset, 1 the first cycle after;
//    dout_valid=0, dout_last=0, dout_size=0, dout=0, count=0, size=0. Reset mid-message discards all data.
//  - Transfer on valid&ready, both sides. din_ready = (count<DEPTH), registered-state only, no comb. path
//    from dout_ready. dout_valid = stage occupied.
//  - Accepted word with din_size=0 and din_last=0 is dropped (no entry, no beat).
//  - Stage (current word, rem bytes, last): loads head of queue when stage empty, or when final chunk of current
//    word handshakes. Bypass: queue empty and stage loading -> accepted din goes straight to stage.
//    Latency din handshake -> dout_valid = 1 cycle when empty; back-to-back words: no bubble.
//  - Chunk: dout = word[DOUT_WIDTH-1:0]; dout_size = min(rem, DOUT_WIDTH/8); on handshake shift word right by
//    DOUT_WIDTH (zero fill), rem -= dout_size; final chunk when rem <= DOUT_WIDTH/8.
//  - dout_last = stage last & final chunk. Zero-size last word: one beat, dout_size=0, dout_last=1, dout=0.
//  - Simultaneous push and pop at count=DEPTH: din_ready=0 (no pass-through when full). Push+pop otherwise:
//    count unchanged. Pointers wrap modulo DEPTH.
//  - size = sum of queued din_size + stage rem; updated same edge as handshakes.
//  - din_size > DIN_WIDTH/8: undefined; sim assertion flags it.
// STRUCTURE
//  - friet_stream_pkg.vh: byte-count helper functions (min, log2), common size/last field layout.
//  - Sub-module friet_stream_fifo: DEPTH x (DIN_WIDTH+DIN_SIZE_WIDTH+2) ring, wr/rd ptr, count, async rst_n.
//  - Top: bypass mux, output stage regs, chunk size/last/zero-mask logic, size accumulator.
// TESTING
//  1 Reset mid-stream: 3 words queued, rst_n low 1 cycle -> count=0, size=0, dout_valid=0; no stale beats after.
//  2 One word size 16, last=1, dout_ready=1 -> dout_valid 1 cycle later; 4 beats size 4, last only on beat 4.
//  3 Word size 10, last=1, ZERO_TAIL=1 -> beats 4,4,2; beat 3 dout[31:16]=0, dout_last=1.
//  4 dout_ready=0, push 5 words -> 1 in stage + 4 queued, din_ready=0 at count=4; release -> 20 beats, order kept.
//  5 Zero-size words: size 0 last=0 -> no beat; size 0 last=1 -> single beat dout_size=0 dout_last=1.
//  6 Continuous random valid/ready, 1000 words -> byte stream and last markers match scoreboard; size tracks.

Source files
------------

// File: rtl/friet_stream_buffer_out_fifo_pkg.sv
// friet_stream_buffer_out_fifo_pkg: default geometry and byte-count helpers for the output FIFO
package friet_stream_buffer_out_fifo_pkg;
  localparam int DIN_W_DEF = 128;
  localparam int DIN_SW_DEF = 4;
  localparam int DOUT_W_DEF = 32;
  localparam int DOUT_SW_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int DEPTH_W_DEF = 2;
  function automatic int min_u(input int a, input int b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/friet_stream_buffer_out_fifo_if.sv
// friet_stream_buffer_out_fifo_if: wide input stream, narrow output stream and occupancy status
interface friet_stream_buffer_out_fifo_if
  import friet_stream_buffer_out_fifo_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_W_DEF,
  parameter int DIN_SIZE_WIDTH = DIN_SW_DEF,
  parameter int DOUT_WIDTH = DOUT_W_DEF,
  parameter int DOUT_SIZE_WIDTH = DOUT_SW_DEF,
  parameter int DEPTH_WIDTH = DEPTH_W_DEF
);
  logic [DIN_WIDTH-1:0] din;
  logic [DIN_SIZE_WIDTH:0] din_size;
  logic din_last;
  logic din_valid;
  logic din_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic [DOUT_SIZE_WIDTH:0] dout_size;
  logic dout_valid;
  logic dout_ready;
  logic dout_last;
  logic [DEPTH_WIDTH:0] count;
  logic [DIN_SIZE_WIDTH+DEPTH_WIDTH:0] size;
  modport master(output din, din_size, din_last, din_valid, dout_ready,
                 input din_ready, dout, dout_size, dout_valid, dout_last, count, size);
  modport slave(input din, din_size, din_last, din_valid, dout_ready,
                output din_ready, dout, dout_size, dout_valid, dout_last, count, size);
endinterface

// File: rtl/friet_stream_buffer_out_fifo_fifo.sv
// friet_stream_buffer_out_fifo_fifo: DEPTH-entry ring of {last, size, word} entries
module friet_stream_buffer_out_fifo_fifo #(
  parameter int W = 134,
  parameter int DEPTH = 4,
  parameter int DEPTH_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_WIDTH:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q + DEPTH_WIDTH'(push);
    rd_d = rd_q + DEPTH_WIDTH'(pop);
    cnt_d = cnt_q + (DEPTH_WIDTH+1)'(push) - (DEPTH_WIDTH+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = cnt_q == '0;
endmodule

// File: rtl/friet_stream_buffer_out_fifo.sv
// friet_stream_buffer_out_fifo: queued wide words drained as narrow chunks with tail zeroing and byte count
module friet_stream_buffer_out_fifo
  import friet_stream_buffer_out_fifo_pkg::*;
#(
  parameter int DIN_WIDTH = DIN_W_DEF,
  parameter int DIN_SIZE_WIDTH = DIN_SW_DEF,
  parameter int DOUT_WIDTH = DOUT_W_DEF,
  parameter int DOUT_SIZE_WIDTH = DOUT_SW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DEPTH_WIDTH = DEPTH_W_DEF,
  parameter int ZERO_TAIL = 1
) (
  input logic clk,
  input logic rst_n,
  friet_stream_buffer_out_fifo_if.slave bus
);
  localparam int DB = DOUT_WIDTH / 8;
  localparam int SW = DIN_SIZE_WIDTH + 1;
  localparam int OSW = DOUT_SIZE_WIDTH + 1;
  localparam int CW = DEPTH_WIDTH + 1;
  localparam int TW = DIN_SIZE_WIDTH + DEPTH_WIDTH + 1;
  localparam int EW = DIN_WIDTH + SW + 1;
  logic rdy_q, rdy_d, stg_v_q, stg_v_d, last_q, last_d;
  logic [DIN_WIDTH-1:0] word_q, word_d;
  logic [SW-1:0] rem_q, rem_d;
  logic [TW-1:0] size_q, size_d;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic empty, din_ready, din_fire, dout_fire, drop, fin, load, bypass, push, pop;
  logic [OSW-1:0] csize;
  logic [DOUT_WIDTH-1:0] mask;
  assign din_ready = rdy_q & (count < CW'(DEPTH));
  assign din_fire = bus.din_valid & din_ready;
  assign drop = (bus.din_size == '0) & ~bus.din_last;
  assign dout_fire = stg_v_q & bus.dout_ready;
  assign fin = rem_q <= SW'(DB);
  assign load = ~stg_v_q | (dout_fire & fin);
  assign bypass = load & empty;
  assign pop = load & ~empty;
  assign push = din_fire & ~drop & ~bypass;
  assign csize = OSW'(min_u(int'(rem_q), DB));
  friet_stream_buffer_out_fifo_fifo #(.W(EW), .DEPTH(DEPTH), .DEPTH_WIDTH(DEPTH_WIDTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .wdata({bus.din_last, bus.din_size, bus.din}),
    .pop(pop), .rdata(head), .count(count), .empty(empty)
  );
  always_comb begin
    rdy_d = 1'b1;
    stg_v_d = stg_v_q;
    {last_d, rem_d, word_d} = {last_q, rem_q, word_q};
    if (pop) begin
      stg_v_d = 1'b1;
      {last_d, rem_d, word_d} = head;
    end else if (bypass) begin
      stg_v_d = din_fire & ~drop;
      {last_d, rem_d, word_d} = stg_v_d ? {bus.din_last, bus.din_size, bus.din} : '0;
    end else if (dout_fire) begin
      word_d = word_q >> DOUT_WIDTH;
      rem_d = rem_q - SW'(csize);
    end
    size_d = size_q + (din_fire ? TW'(bus.din_size) : TW'(0)) - (dout_fire ? TW'(csize) : TW'(0));
    mask = '0;
    for (int b = 0; b < DB; b++) mask[b*8 +: 8] = (ZERO_TAIL == 0 || b < int'(csize)) ? 8'hff : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_q <= 1'b0;
      stg_v_q <= 1'b0;
      last_q <= 1'b0;
      word_q <= '0;
      rem_q <= '0;
      size_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      stg_v_q <= stg_v_d;
      last_q <= last_d;
      word_q <= word_d;
      rem_q <= rem_d;
      size_q <= size_d;
    end
  assign bus.din_ready = din_ready;
  assign bus.dout = word_q[DOUT_WIDTH-1:0] & mask;
  assign bus.dout_size = csize;
  assign bus.dout_valid = stg_v_q;
  assign bus.dout_last = stg_v_q & last_q & fin;
  assign bus.count = count;
  assign bus.size = size_q;
  a_din_size: assert property (@(posedge clk) disable iff (!rst_n)
    bus.din_valid |-> bus.din_size <= SW'(DIN_WIDTH / 8));
endmodule

// File: tb/tb_friet_stream_buffer_out_fifo.sv
// tb_friet_stream_buffer_out_fifo: beat-level scoreboard plus directed literal checks and random traffic
module tb_friet_stream_buffer_out_fifo;
  typedef struct {
    logic [31:0] d;
    int sz;
    bit last;
    bit eow;
  } beat_t;
  logic clk, rst_n;
  friet_stream_buffer_out_fifo_if bus();
  friet_stream_buffer_out_fifo dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  beat_t exp_q[$];
  beat_t got[$];
  beat_t cb, mb;
  int words, bytes, s_m, nb_m;
  bit warm;
  int n_chk, n_pass;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask
  function automatic logic [127:0] mkword(input int base);
    logic [127:0] w;
    for (int b = 0; b < 16; b++) w[8*b +: 8] = 8'(base + b);
    return w;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      words = 0;
      bytes = 0;
      warm = 1'b0;
      chk("rst_dout_valid", bus.dout_valid, 0);
      chk("rst_dout_last", bus.dout_last, 0);
      chk("rst_dout_size", bus.dout_size, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_size", bus.size, 0);
      chk("rst_din_ready", bus.din_ready, 0);
    end else begin
      chk("dout_valid", bus.dout_valid, words > 0);
      chk("count", bus.count, words > 0 ? words - 1 : 0);
      chk("size", bus.size, bytes);
      chk("din_ready", bus.din_ready, warm && (words > 0 ? words - 1 : 0) < 4);
      if (bus.dout_valid && bus.dout_ready) begin
        cb.d = bus.dout;
        cb.sz = int'(bus.dout_size);
        cb.last = bus.dout_last;
        cb.eow = 1'b0;
        got.push_back(cb);
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          mb = exp_q.pop_front();
          chk("beat_data", cb.d, mb.d);
          chk("beat_size", cb.sz, mb.sz);
          chk("beat_last", cb.last, mb.last);
          bytes -= mb.sz;
          if (mb.eow) words--;
        end
      end
      if (bus.din_valid && bus.din_ready) begin
        s_m = int'(bus.din_size);
        if (s_m != 0 || bus.din_last) begin
          words++;
          bytes += s_m;
          nb_m = s_m == 0 ? 1 : (s_m + 3) / 4;
          for (int k = 0; k < nb_m; k++) begin
            mb.sz = s_m - 4 * k > 4 ? 4 : s_m - 4 * k;
            mb.d = '0;
            for (int j = 0; j < mb.sz; j++) mb.d[8*j +: 8] = bus.din[8*(4*k+j) +: 8];
            mb.eow = k == nb_m - 1;
            mb.last = bus.din_last && mb.eow;
            exp_q.push_back(mb);
          end
        end
      end
      warm = 1'b1;
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_word(input logic [127:0] d, input int s, input bit l);
    bit acc;
    int n;
    bus.din = d;
    bus.din_size = 5'(s);
    bus.din_last = l;
    bus.din_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.din_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("push_timeout", 0, 1);
    bus.din_valid = 1'b0;
  endtask
  task automatic chk_beat(input string name, input int i, input logic [31:0] d, input int sz, input bit l);
    if (i >= got.size()) chk({name, "_missing"}, i, got.size());
    else begin
      chk({name, "_d"}, got[i].d, d);
      chk({name, "_sz"}, got[i].sz, sz);
      chk({name, "_last"}, got[i].last, l);
    end
  endtask
  initial begin
    bit acc;
    int sent, cyc;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.din = '0;
    bus.din_size = '0;
    bus.din_last = 1'b0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(2);
    got.delete();
    push_word(mkword(0), 16, 1'b1);
    chk("t2_valid_next_cycle", bus.dout_valid, 1);
    step(6);
    chk("t2_beats", got.size(), 4);
    chk_beat("t2_b0", 0, 32'h03020100, 4, 1'b0);
    chk_beat("t2_b2", 2, 32'h0b0a0908, 4, 1'b0);
    chk_beat("t2_b3", 3, 32'h0f0e0d0c, 4, 1'b1);
    got.delete();
    push_word(mkword(0), 10, 1'b1);
    step(6);
    chk("t3_beats", got.size(), 3);
    chk_beat("t3_b1", 1, 32'h07060504, 4, 1'b0);
    chk_beat("t3_b2", 2, 32'h00000908, 2, 1'b1);
    got.delete();
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(mkword(16 * k), 16, k == 4);
    @(negedge clk);
    chk("t4_full_ready", bus.din_ready, 0);
    chk("t4_full_count", bus.count, 4);
    chk("t4_full_size", bus.size, 80);
    step(1);
    bus.dout_ready = 1'b1;
    step(25);
    chk("t4_beats", got.size(), 20);
    chk_beat("t4_w0", 0, 32'h03020100, 4, 1'b0);
    chk_beat("t4_w4", 16, 32'h43424140, 4, 1'b0);
    chk_beat("t4_end", 19, 32'h4f4e4d4c, 4, 1'b1);
    got.delete();
    push_word(mkword(32), 0, 1'b0);
    push_word(mkword(48), 0, 1'b1);
    step(4);
    chk("t5_beats", got.size(), 1);
    chk_beat("t5_b0", 0, 32'h0, 0, 1'b1);
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_word(mkword(16 * k), 16, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t1_count", bus.count, 0);
    chk("t1_size", bus.size, 0);
    chk("t1_valid", bus.dout_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    bus.dout_ready = 1'b1;
    step(10);
    chk("t1_no_stale", got.size(), 0);
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 30000) begin
      if (!bus.din_valid && $urandom_range(0, 3) != 0) begin
        bus.din = {$urandom, $urandom, $urandom, $urandom};
        bus.din_size = 5'($urandom_range(0, 16));
        bus.din_last = $urandom_range(0, 3) == 0;
        bus.din_valid = 1'b1;
      end
      bus.dout_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      acc = bus.din_valid && bus.din_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        bus.din_valid = 1'b0;
      end
    end
    chk("t6_all_sent", sent, 1000);
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b1;
    step(100);
    chk("t6_drained_beats", exp_q.size(), 0);
    chk("t6_drained_size", bus.size, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
